scalar_vector_mover: RTL and testbench
======================================

Name: scalar_vector_mover

Overview:
- Memory-side initiator that drives the scalar data memory port (CLK, WE, A, WD, RD).
- On one command, moves a whole vector register between the vector datapath and scalar memory.
- Store scatters LANES words out to memory; load gathers LANES words into a vector.
- Sits between the vector load/store decode and the scalar memory. It is the only master of the memory port during vector memory instructions.

Parameters:
- LANES, 4, number of 32-bit elements per vector (power of two, 2..16).
- DATA_W, 32, element and memory word width.
- MEM_RD_LAT, 0, memory read latency in cycles: 0 = combinational RD, 1 = registered RD.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  command strobe; sampled only in IDLE.
- OP  in  1  0 = load (memory to vector), 1 = store (vector to memory); captured with START.
- BASE  in  32  word address of element 0; captured with START.
- STRIDE  in  32  word-address increment between elements (unsigned, modulo 2^32); captured with START.
- VWD  in  LANES*DATA_W  store vector; lane i = bits [i*DATA_W +: DATA_W]; captured with START.
- VRD  out  LANES*DATA_W  gathered load vector, same lane packing; holds its value until the next load completes.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- MEM_WE  out  1  memory write enable.
- MEM_A  out  32  memory word address.
- MEM_WD  out  DATA_W  memory write data.
- MEM_RD  in  DATA_W  memory read data.

Behaviour:
- Reset (async, RST_N=0): state IDLE; BUSY, DONE, MEM_WE = 0; MEM_A, MEM_WD = 0; VRD = 0; lane counter = 0.
  - Takes effect immediately, also mid-command. The partial command is abandoned, with no further writes.
- States: IDLE, STORE, LOAD, DRAIN, FIN.
- IDLE:
  - START=1 at an edge captures OP/BASE/STRIDE/VWD and sets element index i=0.
  - Next state is STORE if OP=1, otherwise LOAD.
  - START while BUSY=1 is ignored (no queuing).
- Address generation: MEM_A(i) = BASE + i*STRIDE, computed as a running accumulator (addr += STRIDE), truncated to 32 bits so it wraps.
- STORE:
  - Runs for exactly LANES cycles, element i in cycle i.
  - Each cycle: MEM_WE=1, MEM_A=addr(i), MEM_WD=lane i of the captured VWD.
  - After element LANES-1, go to FIN.
- LOAD, MEM_RD_LAT=0:
  - Cycle i presents MEM_A=addr(i) with MEM_WE=0.
  - MEM_RD is written into VRD lane i at the closing edge.
  - After LANES cycles, go to FIN.
- LOAD, MEM_RD_LAT=1:
  - Cycle i presents addr(i); MEM_RD sampled in cycle i+1 is written into lane i.
  - After the LANES address cycles, one DRAIN cycle (MEM_A held, MEM_WE=0) captures the last lane, then go to FIN.
- VRD update rule: each lane is written as it arrives. Lanes not yet written keep their old values until the load completes.
- FIN: DONE=1 for exactly one cycle, MEM_WE=0, then IDLE.
  - A START in the FIN cycle is ignored.
  - START may be accepted in the first IDLE cycle after FIN.
- Latency (START edge to DONE high):
  - Store: LANES+1 cycles.
  - Load: LANES+1+MEM_RD_LAT cycles.
- Outside STORE: MEM_WE=0 and MEM_WD=0.
- In IDLE: MEM_A=0.
- STRIDE=0 is legal: every element uses BASE. A store writes BASE repeatedly, and the last lane wins.

Decomposition:
- Shared package (vector unit package):
  - DATA_W constant.
  - mover_op_t enum {OP_LOAD=0, OP_STORE=1}.
  - mover_state_t enum {IDLE, STORE, LOAD, DRAIN, FIN}.
- One sub-module, scalar_addr_gen:
  - Contains the lane counter (log2(LANES)+1 bits) and the 32-bit stride accumulator.
  - Interface: load (BASE, STRIDE), step, addr, idx, last.
- The FSM, VWD capture register and VRD lane register stay in scalar_vector_mover.

Test Plan:
1. LANES=4, store, BASE=0, STRIDE=1, VWD lanes {10,20,30,40}
   -> MEM_WE=1 for 4 consecutive cycles; (A,WD) = (0,10),(1,20),(2,30),(3,40); DONE pulses 5 cycles after START; BUSY low afterwards.
2. Load of the test-1 addresses against a combinational-read memory model
   -> MEM_WE=0 throughout; VRD lanes = {10,20,30,40} when DONE=1; DONE at START+5.
3. Store, BASE=5, STRIDE=3
   -> addresses 5, 8, 11, 14; reloading with the same BASE/STRIDE returns identical lanes.
4. Wrap-around: BASE=32'hFFFF_FFFE, STRIDE=1
   -> addresses FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
5. Second START in the cycle after acceptance, with different BASE -> ignored, only the original addresses are issued. Separately, RST_N=0 in the 2nd store cycle -> MEM_WE, BUSY, DONE drop at once; 3rd and 4th words are never written; a fresh START after release completes normally.
6. MEM_RD_LAT=1 with a registered-read memory model, load of test-1 data
   -> 4 address cycles plus 1 DRAIN cycle; VRD = {10,20,30,40}; DONE at START+6.

Source files
------------

// File: rtl/scalar_vector_mover_pkg.sv
// Shared types and widths for the vector unit's scalar memory mover.
package scalar_vector_mover_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } mover_op_t;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    DRAIN,
    FIN
  } mover_state_t;

endpackage

// File: rtl/scalar_addr_gen.sv
// Element counter plus running stride accumulator producing addr(i) = base + i*stride.
module scalar_addr_gen import scalar_vector_mover_pkg::*; #(
  parameter  int LANES = 4,
  localparam int CNT_W = $clog2(LANES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  idx,
  output logic              last
);

  logic [ADDR_W-1:0] stride_q;

  // The accumulator wraps modulo 2^32, which is the intended address behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      stride_q <= '0;
      idx      <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
      idx      <= '0;
    end else if (clear) begin
      addr <= '0;
      idx  <= '0;
    end else if (step) begin
      addr <= addr + stride_q;
      idx  <= idx + CNT_W'(1);
    end
  end

  assign last = (idx == CNT_W'(LANES - 1));

endmodule

// File: rtl/scalar_vector_mover.sv
// Moves one whole vector register between the vector datapath and scalar memory, one word per cycle.
module scalar_vector_mover #(
  parameter int LANES      = 4,
  parameter int DATA_W     = scalar_vector_mover_pkg::DATA_W,
  parameter int MEM_RD_LAT = 0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       op,
  input  logic [scalar_vector_mover_pkg::ADDR_W-1:0] base,
  input  logic [scalar_vector_mover_pkg::ADDR_W-1:0] stride,
  input  logic [LANES*DATA_W-1:0]                    vwd,
  output logic [LANES*DATA_W-1:0]                    vrd,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       mem_we,
  output logic [scalar_vector_mover_pkg::ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0]                          mem_wd,
  input  logic [DATA_W-1:0]                          mem_rd
);
  import scalar_vector_mover_pkg::*;

  localparam int CNT_W = $clog2(LANES) + 1;

  mover_state_t             state;
  logic [LANES*DATA_W-1:0]  vwd_q;
  logic                     ag_load;
  logic                     ag_step;
  logic                     ag_clear;
  logic                     ag_last;
  logic [CNT_W-1:0]         ag_idx;
  logic [CNT_W-1:0]         next_lane;
  logic [CNT_W-1:0]         rd_lane;
  logic                     rd_en;

  scalar_addr_gen #(.LANES(LANES)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ag_load),
    .step   (ag_step),
    .clear  (ag_clear),
    .base   (base),
    .stride (stride),
    .addr   (mem_a),
    .idx    (ag_idx),
    .last   (ag_last)
  );

  assign ag_load  = (state == IDLE) && start;
  assign ag_clear = (state == FIN);

  // With a registered read, data for element i shows up while element i+1 is addressed.
  always_comb begin
    ag_step   = 1'b0;
    rd_en     = 1'b0;
    rd_lane   = ag_idx;
    next_lane = ag_idx + CNT_W'(1);
    case (state)
      STORE: ag_step = !ag_last;
      LOAD: begin
        ag_step = !ag_last;
        if (MEM_RD_LAT == 0) begin
          rd_en = 1'b1;
        end else begin
          rd_en   = (ag_idx != '0);
          rd_lane = ag_idx - CNT_W'(1);
        end
      end
      DRAIN:   rd_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      mem_we <= 1'b0;
      mem_wd <= '0;
      vwd_q  <= '0;
      vrd    <= '0;
    end else begin
      done <= 1'b0;
      if (rd_en) vrd[int'(rd_lane)*DATA_W +: DATA_W] <= mem_rd;
      case (state)
        IDLE: begin
          if (start) begin
            vwd_q <= vwd;
            busy  <= 1'b1;
            if (mover_op_t'(op) == OP_STORE) begin
              state  <= STORE;
              mem_we <= 1'b1;
              mem_wd <= vwd[DATA_W-1:0];
            end else begin
              state <= LOAD;
            end
          end
        end
        STORE: begin
          if (ag_last) begin
            state  <= FIN;
            done   <= 1'b1;
            mem_we <= 1'b0;
            mem_wd <= '0;
          end else begin
            mem_wd <= vwd_q[int'(next_lane)*DATA_W +: DATA_W];
          end
        end
        LOAD: begin
          if (ag_last) begin
            if (MEM_RD_LAT == 0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
          mem_wd <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_vector_mover.sv
// Drives a combinational-read and a registered-read mover side by side against an array memory model.
module tb_scalar_vector_mover;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int VW    = LANES * DW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          op        = 1'b0;
  logic [31:0]   base      = '0;
  logic [31:0]   stride    = '0;
  logic [VW-1:0] vwd       = '0;
  logic          mem_clear = 1'b1;

  logic [VW-1:0] vrd0, vrd1;
  logic          busy0, busy1, done0, done1, we0, we1;
  logic [31:0]   a0, a1;
  logic [DW-1:0] wd0, wd1, rd0, rd1;

  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] emem [256];
  logic [VW-1:0] evrd = '0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scalar_vector_mover #(.LANES(LANES), .DATA_W(DW), .MEM_RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base(base), .stride(stride),
    .vwd(vwd), .vrd(vrd0), .busy(busy0), .done(done0), .mem_we(we0), .mem_a(a0),
    .mem_wd(wd0), .mem_rd(rd0)
  );

  scalar_vector_mover #(.LANES(LANES), .DATA_W(DW), .MEM_RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base(base), .stride(stride),
    .vwd(vwd), .vrd(vrd1), .busy(busy1), .done(done1), .mem_we(we1), .mem_a(a1),
    .mem_wd(wd1), .mem_rd(rd1)
  );

  // Memories fold the 32-bit address onto 256 words; the model folds identically.
  assign rd0 = mem0[a0[7:0]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (we0) mem0[a0[7:0]] <= wd0;
      if (we1) mem1[a1[7:0]] <= wd1;
    end
    rd1 <= mem1[a1[7:0]];
  end

  task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                             input logic [VW-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDut(input string nm, input int k, input int dc,
                          input logic bsy, input logic dn, input logic we,
                          input logic [31:0] a, input logic [DW-1:0] wd,
                          input logic [VW-1:0] vr, input logic [VW-1:0] evr,
                          input logic is_store, input logic [31:0] b, input logic [31:0] s,
                          input logic [VW-1:0] v);
    logic [VW-1:0] vv;
    logic [31:0]   ea;
    logic [DW-1:0] ewd;
    logic          act;
    vv  = v;
    act = is_store && (k <= LANES);
    ewd = '0;
    if (act) ewd = vv[(k-1)*DW +: DW];
    checkOutput($sformatf("%s busy k%0d", nm, k), bsy, (k <= dc));
    checkOutput($sformatf("%s done k%0d", nm, k), dn, (k == dc));
    checkOutput($sformatf("%s we k%0d", nm, k), we, act);
    checkOutput($sformatf("%s wd k%0d", nm, k), wd, ewd);
    if (k <= LANES) begin
      ea = b + s * 32'(k - 1);
      checkOutput($sformatf("%s addr k%0d", nm, k), a, ea);
    end else if (dc == LANES + 2 && k == LANES + 1) begin
      ea = b + s * 32'(LANES - 1);
      checkOutput($sformatf("%s drain addr k%0d", nm, k), a, ea);
    end else if (k > dc) begin
      checkOutput($sformatf("%s idle addr k%0d", nm, k), a, 32'd0);
    end
    if (k >= dc) checkOutput($sformatf("%s vrd k%0d", nm, k), vr, evr);
  endtask

  // One command on both movers, checked cycle by cycle from the START cycle (k=0).
  task automatic applyStimulus(input logic is_store, input logic [31:0] b, input logic [31:0] s,
                               input logic [VW-1:0] v, input bit glitch);
    logic [VW-1:0] vv;
    logic [VW-1:0] expect_vrd;
    logic [31:0]   ea;
    int            dc0, dc1;
    vv         = v;
    expect_vrd = evrd;
    if (!is_store) begin
      for (int i = 0; i < LANES; i++) begin
        ea = b + s * 32'(i);
        expect_vrd[i*DW +: DW] = emem[ea[7:0]];
      end
    end
    dc0 = LANES + 1;
    dc1 = is_store ? LANES + 1 : LANES + 2;
    @(negedge clk);
    checkOutput("idle busy0", busy0, 1'b0);
    checkOutput("idle addr0", a0, 32'd0);
    checkOutput("idle busy1", busy1, 1'b0);
    checkOutput("idle we1", we1, 1'b0);
    op     = is_store;
    base   = b;
    stride = s;
    vwd    = v;
    start  = 1'b1;
    for (int k = 1; k <= dc1 + 1; k++) begin
      @(negedge clk);
      checkDut("m0", k, dc0, busy0, done0, we0, a0, wd0, vrd0, expect_vrd, is_store, b, s, v);
      checkDut("m1", k, dc1, busy1, done1, we1, a1, wd1, vrd1, expect_vrd, is_store, b, s, v);
      start = 1'b0;
      if (glitch && (k == 1 || (is_store && k == dc0))) begin
        start = 1'b1;
        base  = b ^ 32'h0000_0100;
      end
    end
    start = 1'b0;
    evrd  = expect_vrd;
    if (is_store) begin
      for (int i = 0; i < LANES; i++) begin
        ea = b + s * 32'(i);
        emem[ea[7:0]] = vv[i*DW +: DW];
      end
      for (int i = 0; i < LANES; i++) begin
        ea = b + s * 32'(i);
        checkOutput($sformatf("mem0 lane%0d", i), mem0[ea[7:0]], emem[ea[7:0]]);
        checkOutput($sformatf("mem1 lane%0d", i), mem1[ea[7:0]], emem[ea[7:0]]);
      end
    end
  endtask

  task automatic resetMidStore(input logic [31:0] b, input logic [VW-1:0] v);
    logic [31:0] ea;
    @(negedge clk);
    op     = 1'b1;
    base   = b;
    stride = 32'd1;
    vwd    = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("prereset we0", we0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst we0", we0, 1'b0);
    checkOutput("rst busy0", busy0, 1'b0);
    checkOutput("rst done0", done0, 1'b0);
    checkOutput("rst addr0", a0, 32'd0);
    checkOutput("rst wd0", wd0, '0);
    checkOutput("rst vrd0", vrd0, '0);
    checkOutput("rst we1", we1, 1'b0);
    checkOutput("rst busy1", busy1, 1'b0);
    checkOutput("rst vrd1", vrd1, '0);
    emem[b[7:0]] = v[DW-1:0];
    evrd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post rst busy0", busy0, 1'b0);
    for (int i = 0; i < LANES; i++) begin
      ea = b + 32'(i);
      checkOutput($sformatf("rst mem0 lane%0d", i), mem0[ea[7:0]], emem[ea[7:0]]);
      checkOutput($sformatf("rst mem1 lane%0d", i), mem1[ea[7:0]], emem[ea[7:0]]);
    end
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [31:0]   b, s;
    for (int i = 0; i < 256; i++) emem[i] = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy0", busy0, 1'b0);
    checkOutput("reset done0", done0, 1'b0);
    checkOutput("reset we0", we0, 1'b0);
    checkOutput("reset addr0", a0, 32'd0);
    checkOutput("reset wd0", wd0, '0);
    checkOutput("reset vrd0", vrd0, '0);
    checkOutput("reset busy1", busy1, 1'b0);
    checkOutput("reset vrd1", vrd1, '0);
    mem_clear = 1'b0;
    rst_n     = 1'b1;

    $display("[TB] unit-stride store and load");
    applyStimulus(1'b1, 32'd0, 32'd1, {32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd1, '0, 1'b0);
    checkOutput("t2 vrd0 const", vrd0, {32'd40, 32'd30, 32'd20, 32'd10});
    checkOutput("t6 vrd1 const", vrd1, {32'd40, 32'd30, 32'd20, 32'd10});

    $display("[TB] strided, wrapping and stride-0 transfers");
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 32'd5, 32'd3, v, 1'b0);
    applyStimulus(1'b0, 32'd5, 32'd3, '0, 1'b0);
    checkOutput("t3 reload", vrd0, v);
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 32'hFFFF_FFFE, 32'd1, v, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFE, 32'd1, '0, 1'b0);
    checkOutput("t4 wrap reload", vrd1, v);
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 32'h0000_0033, 32'd0, v, 1'b0);
    applyStimulus(1'b0, 32'h0000_0033, 32'd0, '0, 1'b0);
    checkOutput("stride0 last wins", vrd0[DW-1:0], v[3*DW +: DW]);

    $display("[TB] ignored START and mid-command reset");
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 32'h0000_0080, 32'd2, v, 1'b1);
    applyStimulus(1'b0, 32'h0000_0080, 32'd2, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0040, 32'd1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
    resetMidStore(32'h0000_0040, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 32'h0000_0060, 32'd1, v, 1'b0);
    applyStimulus(1'b0, 32'h0000_0060, 32'd1, '0, 1'b0);

    $display("[TB] randomized transfers");
    for (int r = 0; r < 4; r++) begin
      b = $urandom();
      s = $urandom();
      v = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(1'b1, b, s, v, 1'b0);
      applyStimulus(1'b0, b, s, '0, 1'b0);
      applyStimulus(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
